// File: rtl/stopwatch_display_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_display_pkg
// Shared types and constants for the stopwatch 7-segment display driver.
//   digit_e      : scan state, one value per display digit (DIG3 = leftmost).
//   sw_value_t   : {minutes, seconds, tenths} as captured from the counter.
//   SEG_BLANK    : all segments off (active-low).
//   SEG_DASH     : only segment g lit (active-low).
//   DP_N_PATTERN : active-low decimal point per digit, indexed by digit_e.
//   anode_n()    : one-hot-low anode pattern for a digit.
// -----------------------------------------------------------------------------
package stopwatch_display_pkg;

  // Encoding equals the anode bit position, so the scan order is a decrement
  // and the digit value can index the anode / dp patterns directly.
  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

  typedef struct packed {
    logic [3:0] m;
    logic [5:0] ss;
    logic [3:0] d;
  } sw_value_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // dp lit (0) after minutes (DIG3) and after seconds ones (DIG1): M.SS.D
  localparam logic [3:0] DP_N_PATTERN = 4'b0101;

  function automatic logic [3:0] anode_n(input digit_e dig);
    return ~(4'b0001 << dig);
  endfunction

endpackage

// File: rtl/stopwatch_display_seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD to 7-segment decoder, active-low, {g,f,e,d,c,b,a}.
//   value : 4-bit digit value; anything above 9 decodes to a dash.
//   seg   : active-low segment pattern.
// -----------------------------------------------------------------------------
module seg7_decode
  import stopwatch_display_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (value)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_display.sv
// -----------------------------------------------------------------------------
// stopwatch_display
// Drives a 4-digit common-anode multiplexed 7-segment display as M.SS.D from
// the stopwatch counter. The counter value is double-sampled and copied into a
// snapshot only at frame boundaries (DIG0 -> DIG3) when two consecutive
// samples agree and hold is low, so a frame never shows a torn value.
//
// Parameters:
//   REFRESH_DIV : clk cycles per digit slot (>= GUARD+1).
//   GUARD       : cycles at the start of each slot with all anodes off (>= 1).
// Ports:
//   clk  : system clock.
//   clr  : asynchronous active-high reset.
//   M    : minutes (binary, 0-9 valid).
//   SS   : seconds (binary, 0-59 valid).
//   D    : tenths (binary, 0-9 valid).
//   hold : 1 freezes the displayed value (lap).
//   seg  : {g,f,e,d,c,b,a}, active-low, registered.
//   dp   : decimal point, active-low, registered.
//   an   : anodes, active-low, an[3] = leftmost digit, registered.
// Build option:
//   STOPWATCH_DISPLAY_LZ_BLANK_EN : blank a leading zero minute digit and,
//   when minutes are blank, a zero seconds-tens digit.
// -----------------------------------------------------------------------------
module stopwatch_display
  import stopwatch_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] M,
  input  logic [5:0] SS,
  input  logic [3:0] D,
  input  logic       hold,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] GUARD_V  = DIV_W'(GUARD);

  logic [DIV_W-1:0] div_q, div_d;
  digit_e           state_q, state_d;
  sw_value_t        sample_a_q, sample_b_q;
  sw_value_t        snap_q, snap_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       an_q, an_d;

  logic       slot_end;
  logic       frame_end;
  logic       coherent;
  logic       ss_valid;
  logic [3:0] ss_tens;
  logic [3:0] ss_ones;
  logic [3:0] digit_val;
  logic [6:0] dec_seg;
  logic       lz_blank;

  // Divider, scan state and snapshot update.
  always_comb begin
    slot_end  = (div_q == DIV_LAST);
    frame_end = slot_end && (state_q == DIG0);
    coherent  = (sample_a_q == sample_b_q);

    div_d   = slot_end ? '0 : div_q + 1'b1;
    state_d = slot_end ? digit_e'(state_q - 2'd1) : state_q;

    snap_d = snap_q;
    if (frame_end && !hold && coherent) begin
      snap_d = sample_b_q;
    end
  end

  // Seconds split into BCD; out-of-range seconds become dashes on both digits.
  always_comb begin
    ss_valid = (snap_q.ss < 6'd60);
    ss_tens  = 4'(snap_q.ss / 6'd10);
    ss_ones  = 4'(snap_q.ss % 6'd10);
  end

  always_comb begin
    digit_val = snap_q.d;
    case (state_q)
      DIG3: digit_val = snap_q.m;
      DIG2: digit_val = ss_valid ? ss_tens : 4'hF;
      DIG1: digit_val = ss_valid ? ss_ones : 4'hF;
      DIG0: digit_val = snap_q.d;
      default: digit_val = snap_q.d;
    endcase
  end

  seg7_decode u_seg7_decode (
    .value (digit_val),
    .seg   (dec_seg)
  );

`ifdef STOPWATCH_DISPLAY_LZ_BLANK_EN
  always_comb begin
    lz_blank = 1'b0;
    if (snap_q.m == 4'd0) begin
      if (state_q == DIG3) begin
        lz_blank = 1'b1;
      end else if ((state_q == DIG2) && ss_valid && (ss_tens == 4'd0)) begin
        lz_blank = 1'b1;
      end
    end
  end
`else
  always_comb begin
    lz_blank = 1'b0;
  end
`endif

  // Output stage: guard window blanks everything so the previous digit's
  // segments never ghost onto the newly selected anode.
  always_comb begin
    an_d  = 4'hF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (div_q >= GUARD_V) begin
      an_d = anode_n(state_q);
      if (lz_blank) begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
      end else begin
        seg_d = dec_seg;
        dp_d  = DP_N_PATTERN[state_q];
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      div_q      <= '0;
      state_q    <= DIG3;
      sample_a_q <= '0;
      sample_b_q <= '0;
      snap_q     <= '0;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      an_q       <= 4'hF;
    end else begin
      div_q      <= div_d;
      state_q    <= state_d;
      sample_a_q <= {M, SS, D};
      sample_b_q <= sample_a_q;
      snap_q     <= snap_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule
